mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that responds to the 16-bit single-cycle CPU's data-memory bus; the CPU writes bytes, this block serialises them.
- Sits beside data memory on the CPU load/store port and decodes its own 4-word address window.
- Read data is combinational, so single-cycle loads work unchanged.
- Provides the CPU with a console/debug output path visible in the top-level bench.

---
 rtl/mmio_uart_tx_pkg.sv | 28 ++
 rtl/mmio_uart_tx_fifo.sv | 73 +++++++
 rtl/mmio_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
// Also holds the divider sanitising helper used on BAUDDIV writes.
package mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;
  localparam logic [1:0] UART_CTRL    = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_CNT   = 3;
  localparam int ST_OVF   = 4;

  // A zero divider would make bits last zero clocks; clamp it to one.
  function automatic logic [15:0] fix_div(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO with occupancy count; pushes while full are ignored
// unless a pop happens in the same cycle. Shared with the future RX path.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART 8N1 transmitter on the CPU data bus: 4-word register window, TX FIFO,
// per-frame latched baud divider and a registered "drained" interrupt.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [15:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit_s, wr_s, busy_s, bit_end_s, ovf_set_s;
  logic [1:0]    offset_s;
  logic          fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0]    fifo_rdata_s;
  logic [CW-1:0] fifo_count_s;
  logic [15:0]   status_s;

  uart_state_t   state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic [15:0]   div_lat_q, div_lat_d;
  logic [15:0]   baud_div_q, baud_div_d;
  logic          tx_q, tx_d, ovf_q, ovf_d, ien_q, ien_d, irq_q, irq_d;

  assign hit_s       = (addr[15:2] == BASE_ADDR[15:2]);
  assign offset_s    = addr[1:0];
  assign wr_s        = we & hit_s;
  assign fifo_push_s = wr_s & (offset_s == UART_TXDATA);
  assign ovf_set_s   = fifo_push_s & fifo_full_s & ~fifo_pop_s;
  assign busy_s      = (state_q != IDLE);
  assign bit_end_s   = (baud_cnt_q == (div_lat_q - 16'd1));
  assign tx          = tx_q;
  assign irq         = irq_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Frame sequencer: a new frame loads the shift register and freezes the divider.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = bit_end_s ? 16'd0 : baud_cnt_q + 16'd1;
    div_lat_d  = div_lat_q;
    tx_d       = tx_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      IDLE: begin
        baud_cnt_d = 16'd0;
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_rdata_s;
          div_lat_d  = baud_div_q;
          tx_d       = 1'b0;
          state_d    = START;
        end else begin
          tx_d = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          tx_d = 1'b0;
        end
      end
      DATA: begin
        if (bit_end_s && (bit_idx_q == 3'd7)) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end else if (bit_end_s) begin
          shift_d   = {1'b0, shift_q[7:1]};
          tx_d      = shift_q[1];
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          tx_d = tx_q;
        end
      end
      STOP: begin
        if (bit_end_s && !fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_rdata_s;
          div_lat_d  = baud_div_q;
          tx_d       = 1'b0;
          state_d    = START;
        end else if (bit_end_s) begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end else begin
          tx_d = 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Register writes; a fresh overflow beats a simultaneous ovf clear.
  always_comb begin
    baud_div_d = baud_div_q;
    ovf_d      = ovf_q;
    ien_d      = ien_q;
    if (wr_s) begin
      case (offset_s)
        UART_STATUS:  ovf_d      = wdata[ST_OVF] ? 1'b0 : ovf_q;
        UART_BAUDDIV: baud_div_d = fix_div(wdata);
        UART_CTRL:    ien_d      = wdata[0];
        default:      ovf_d      = ovf_q;
      endcase
    end else begin
      ovf_d = ovf_q;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    irq_d = ien_q & fifo_empty_s & ~busy_s;
  end

  // Combinational read mux so single-cycle loads see data in the same cycle.
  always_comb begin
    status_s           = 16'h0000;
    status_s[ST_BUSY]  = busy_s;
    status_s[ST_FULL]  = fifo_full_s;
    status_s[ST_EMPTY] = fifo_empty_s;
    status_s[ST_CNT]   = |fifo_count_s;
    status_s[ST_OVF]   = ovf_q;
    rdata              = 16'h0000;
    if (re && hit_s) begin
      case (offset_s)
        UART_STATUS:  rdata = status_s;
        UART_BAUDDIV: rdata = baud_div_q;
        UART_CTRL:    rdata = {15'd0, ien_q};
        default:      rdata = 16'h0000;
      endcase
    end else begin
      rdata = 16'h0000;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      div_lat_q  <= 16'd1;
      baud_div_q <= DEFAULT_DIV;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
      ien_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      div_lat_q  <= div_lat_d;
      baud_div_q <= baud_div_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
      ien_q      <= ien_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: expected serial bits are queued when bytes
// are written and popped as the line is sampled at the start and end of each bit.
module tb_mmio_uart_tx;

  localparam logic [15:0] A_TX = 16'hFF00;
  localparam logic [15:0] A_ST = 16'hFF01;
  localparam logic [15:0] A_BD = 16'hFF02;
  localparam logic [15:0] A_CT = 16'hFF03;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] rdata;
  logic        tx, irq;

  int checks = 0;
  int errors = 0;
  bit exp_bit_q[$];
  int exp_len_q[$];
  logic [15:0] rd;

  mmio_uart_tx dut (
    .CLK(CLK), .RST(RST), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .rdata(rdata), .tx(tx), .irq(irq)
  );

  always #5 CLK = ~CLK;

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge CLK);
    #1;
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    addr = a;
    re   = 1'b1;
    #1;
    d  = rdata;
    re = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b, input int div);
    exp_bit_q.push_back(1'b0);
    exp_len_q.push_back(div);
    for (int i = 0; i < 8; i++) begin
      exp_bit_q.push_back(b[i]);
      exp_len_q.push_back(div);
    end
    exp_bit_q.push_back(1'b1);
    exp_len_q.push_back(div);
  endtask

  // Waits (bounded) for the start bit, then checks every queued bit back to back.
  task automatic monitor(input int budget);
    int n;
    bit e;
    int len;
    n = 0;
    while (tx !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("start_found", {15'd0, tx}, 16'd0);
    if (tx !== 1'b0) begin
      exp_bit_q.delete();
      exp_len_q.delete();
    end
    while (exp_bit_q.size() > 0) begin
      e   = exp_bit_q.pop_front();
      len = exp_len_q.pop_front();
      chk("bit_first_clk", {15'd0, tx}, {15'd0, e});
      repeat (len - 1) tick();
      chk("bit_last_clk", {15'd0, tx}, {15'd0, e});
      tick();
    end
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    chk("tx_in_reset", {15'd0, tx}, 16'd1);
    RST = 1'b1;
    tick();
    bus_read(A_ST, rd); chk("reset_status", rd, 16'h0004);
    bus_read(A_BD, rd); chk("reset_bauddiv", rd, 16'd434);
    bus_read(A_CT, rd); chk("reset_ctrl", rd, 16'h0000);
    chk("reset_irq", {15'd0, irq}, 16'd0);
    chk("reset_tx", {15'd0, tx}, 16'd1);

    // Single byte at divider 4, including the one-edge start latency
    bus_write(A_BD, 16'd4);
    push_frame(8'hA5, 4);
    bus_write(A_TX, 16'h00A5);
    chk("tx_before_start", {15'd0, tx}, 16'd1);
    tick();
    chk("tx_fall_latency", {15'd0, tx}, 16'd0);
    monitor(0);
    bus_read(A_ST, rd); chk("single_done_status", rd, 16'h0004);

    // Back-to-back frames with no idle gap
    bus_write(A_BD, 16'd2);
    push_frame(8'h01, 2);
    push_frame(8'h02, 2);
    push_frame(8'h03, 2);
    fork
      begin
        bus_write(A_TX, 16'h0001);
        bus_write(A_TX, 16'h0002);
        bus_write(A_TX, 16'h0003);
        bus_read(A_ST, rd); chk("b2b_not_full", {15'd0, rd[1]}, 16'd0);
        tick();
        bus_read(A_ST, rd); chk("b2b_not_full_later", {15'd0, rd[1]}, 16'd0);
      end
      monitor(20);
    join
    bus_read(A_ST, rd); chk("b2b_done_status", rd, 16'h0004);

    // Overflow: six fast pushes, one dropped, sticky ovf then clear
    bus_write(A_BD, 16'd100);
    for (int i = 0; i < 5; i++) push_frame(8'h11 + 8'(i), 100);
    fork
      begin
        for (int i = 0; i < 6; i++) bus_write(A_TX, 16'h0011 + 16'(i));
        bus_read(A_ST, rd); chk("ovf_status", rd, 16'h001B);
        bus_write(A_ST, 16'h0010);
        bus_read(A_ST, rd); chk("ovf_cleared", rd, 16'h000B);
      end
      monitor(20);
    join
    bus_read(A_ST, rd); chk("ovf_drained", rd, 16'h0004);

    // Accesses outside the window do nothing
    bus_write(16'h1002, 16'h0007);
    bus_read(A_BD, rd); chk("miss_write_ignored", rd, 16'd100);
    bus_read(16'h1002, rd); chk("miss_read_zero", rd, 16'h0000);
    bus_read(A_TX, rd); chk("txdata_reads_zero", rd, 16'h0000);

    // IRQ and zero divider
    bus_write(A_CT, 16'h0001);
    bus_read(A_CT, rd); chk("ctrl_ien", rd, 16'h0001);
    bus_write(A_BD, 16'h0000);
    bus_read(A_BD, rd); chk("bauddiv_zero_is_one", rd, 16'h0001);
    tick();
    chk("irq_idle_high", {15'd0, irq}, 16'd1);
    bus_write(A_TX, 16'h005A);
    tick();
    chk("irq_tx_start", {15'd0, tx}, 16'd0);
    chk("irq_low_busy", {15'd0, irq}, 16'd0);
    repeat (9) tick();
    chk("irq_stop_tx", {15'd0, tx}, 16'd1);
    chk("irq_low_stop", {15'd0, irq}, 16'd0);
    tick();
    chk("irq_low_at_stop_end", {15'd0, irq}, 16'd0);
    tick();
    chk("irq_high_after", {15'd0, irq}, 16'd1);
    bus_write(A_CT, 16'h0000);
    tick();
    chk("irq_disabled", {15'd0, irq}, 16'd0);

    // Divider change mid-frame only affects the next frame
    bus_write(A_BD, 16'd4);
    push_frame(8'hC3, 4);
    push_frame(8'h3C, 8);
    fork
      begin
        bus_write(A_TX, 16'h00C3);
        bus_write(A_TX, 16'h003C);
        repeat (5) tick();
        bus_write(A_BD, 16'd8);
      end
      monitor(10);
    join
    bus_read(A_ST, rd); chk("midframe_done", rd, 16'h0004);

    // Asynchronous reset in the middle of the data bits
    bus_write(A_TX, 16'h0000);
    bus_write(A_TX, 16'h0077);
    repeat (20) tick();
    chk("tx_low_mid_data", {15'd0, tx}, 16'd0);
    #2 RST = 1'b0;
    #1;
    chk("tx_async_reset", {15'd0, tx}, 16'd1);
    bus_read(A_ST, rd); chk("reset_mid_status", rd, 16'h0004);
    bus_read(A_BD, rd); chk("reset_mid_bauddiv", rd, 16'd434);
    #2 RST = 1'b1;
    tick();
    bus_read(A_ST, rd); chk("after_reset_fifo_empty", rd, 16'h0004);
    repeat (20) tick();
    chk("after_reset_tx_idle", {15'd0, tx}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
